rsc_dec_output_reader: RTL and testbench
========================================

Name: rsc_dec_output_reader

Overview:
Sink-side read controller for the RSC decoder nD output buffer. It detects a filled bank, walks the read address across one block, and captures the registered RAM read data and the bank tag. It then presents the data as a packetised valid/ready stream with sop/eop, and releases the bank with a one-cycle read-empty pulse. It sits directly downstream of the output buffer and drives that buffer's irempty/iraddr inputs.

Parameters:
pADDR_W, 8, buffer read address width (words per bank = 2**pADDR_W max)
pRDAT_W, 2, read data width, equal to the buffer read width (2/4/8)
pTAG_W, 8, tag width
pRLAT, 1, buffer read latency in cycles from iraddr to ordata valid (1..3)
pFIFO_W, 2, log2 of output skid FIFO depth; depth must be >= pRLAT+1

Ports:
iclk  in  1  clock
ireset  in  1  synchronous reset, active high
iclkena  in  1  clock enable; all state holds when low
ilen_m1  in  pADDR_W  block length in read words minus 1; sampled at block start
ibuf_empty  in  1  buffer oempty (no filled bank available)
ibuf_rdata  in  pRDAT_W  buffer ordata
ibuf_rtag  in  pTAG_W  buffer ortag (stable while bank held)
obuf_raddr  out  pADDR_W  buffer iraddr
obuf_rempty  out  1  buffer irempty: one-cycle bank release pulse
oval  out  1  output word valid
osop  out  1  first word of block
oeop  out  1  last word of block
odat  out  pRDAT_W  output word
otag  out  pTAG_W  block tag, valid with every oval
ordy  in  1  downstream ready; a transfer occurs when oval&ordy&iclkena
obusy  out  1  FSM not in IDLE

Behaviour:
- Reset (ireset=1 at a posedge with iclkena=1, and also with iclkena=0): FSM=IDLE, FIFO flushed, in-flight pipe cleared, address counter=0. All outputs 0: oval, osop, oeop, odat, otag, obuf_raddr, obuf_rempty, obusy.
- Reset mid-block: the block is abandoned, with no rempty pulse and no output. In-flight reads are discarded.
- FSM states:
  - IDLE: when ibuf_empty=0, latch len=ilen_m1 and tag=ibuf_rtag, set addr=0, go to READ.
  - READ: issue a read (obuf_raddr=addr, read-issue strobe pushed into a pRLAT-deep valid/sop/eop shift pipe) only when credit>0. credit = FIFO depth - FIFO count - reads in flight. After issuing addr==len, go to DRAIN; otherwise addr++.
  - DRAIN: when the in-flight pipe is empty (last word written to FIFO), assert obuf_rempty for exactly one cycle and go to GAP.
  - GAP: one cycle, letting the buffer's registered oempty update; then go to IDLE.
- The bank is released once its data sits in the FIFO, not when it is output. Reading of the next bank overlaps draining of the FIFO.
- Pipe output: at the cycle pRLAT after issue, ibuf_rdata is written to the FIFO with the issued sop (addr==0) and eop (addr==len) flags.
- The FIFO never overflows, by construction of the credit. Writes and reads of the FIFO in the same cycle are both allowed.
- Output: oval = FIFO not empty. odat/osop/oeop come from the FIFO head. otag is stored per FIFO entry with the word, so tags do not mix across blocks. Outputs hold while ordy=0.
- Address counter width is pADDR_W. len=2**pADDR_W-1 reads every address with no wrap. len=0 gives a single word with osop=oeop=1.
- iclkena=0 freezes FSM, pipe, FIFO and outputs. An obuf_rempty pulse stretches across disabled cycles and counts once.
- Peak throughput with ordy=1 is 1 word/cycle. Block-to-block overhead is pRLAT+2 idle read cycles.

Test Plan:
- pRLAT=1, len_m1=7, tag=0xA5, ordy=1 -> 8 words on 8 consecutive cycles with the RAM contents in order; osop on word 0, oeop on word 7, otag=0xA5 throughout; a single obuf_rempty pulse 1 cycle after the last word is captured.
- len_m1=0 -> one word with osop=oeop=1; exactly one rempty pulse; FSM back in IDLE after GAP.
- ordy toggled 1/0 every cycle, plus a 20-cycle ordy=0 stall -> no lost or duplicated words; FIFO count never exceeds 2**pFIFO_W; obuf_raddr advances only while credit>0.
- Two banks back-to-back (tags 0x11, 0x22; ibuf_empty held low) -> the second block's reads start pRLAT+2 cycles after the first block's last issue; each word carries its own block's tag.
- ireset asserted in the middle of a block (addr=3) -> next cycle all outputs 0, no rempty pulse; after reset the same bank is re-read from addr 0.
- iclkena low for 5 cycles during READ and during the rempty pulse -> output sequence identical to the enabled run; exactly one release per block.

Source files
------------

// File: rtl/rsc_dec_output_reader.sv
// Read controller for the RSC decoder output buffer: walks one filled bank,
// captures the delayed RAM data into a skid FIFO and streams it out as
// sop/eop packets, releasing the bank as soon as its last word is captured.
module rsc_dec_output_reader #(
    parameter int pADDR_W = 8,
    parameter int pRDAT_W = 2,
    parameter int pTAG_W  = 8,
    parameter int pRLAT   = 1,
    parameter int pFIFO_W = 2
) (
    input  logic               iclk,
    input  logic               ireset,
    input  logic               iclkena,
    input  logic [pADDR_W-1:0] ilen_m1,
    input  logic               ibuf_empty,
    input  logic [pRDAT_W-1:0] ibuf_rdata,
    input  logic [pTAG_W-1:0]  ibuf_rtag,
    output logic [pADDR_W-1:0] obuf_raddr,
    output logic               obuf_rempty,
    output logic               oval,
    output logic               osop,
    output logic               oeop,
    output logic [pRDAT_W-1:0] odat,
    output logic [pTAG_W-1:0]  otag,
    input  logic               ordy,
    output logic               obusy
);

    localparam int                 cDEPTH   = 2 ** pFIFO_W;
    localparam logic [pFIFO_W+1:0] cDEPTH_V = (pFIFO_W + 2)'(cDEPTH);

    typedef enum logic [1:0] {IDLE, READ, DRAIN, GAP} state_t;

    state_t               state;
    logic [pADDR_W-1:0]   addr;
    logic [pADDR_W-1:0]   len;
    logic [pTAG_W-1:0]    tag;
    logic                 rempty;

    logic [pRLAT-1:0]     pipe_val;
    logic [pRLAT-1:0]     pipe_sop;
    logic [pRLAT-1:0]     pipe_eop;
    logic [pRLAT-1:0]     val_next;
    logic [pRLAT-1:0]     sop_next;
    logic [pRLAT-1:0]     eop_next;

    logic [pRDAT_W-1:0]   mem_dat [cDEPTH];
    logic [pTAG_W-1:0]    mem_tag [cDEPTH];
    logic                 mem_sop [cDEPTH];
    logic                 mem_eop [cDEPTH];
    logic [pFIFO_W-1:0]   wptr;
    logic [pFIFO_W-1:0]   rptr;
    logic [pFIFO_W:0]     fifo_cnt;

    logic [pFIFO_W+1:0]   inflight;
    logic [pFIFO_W+1:0]   occupancy;
    logic                 issue;
    logic                 issue_sop;
    logic                 issue_eop;
    logic                 pipe_drains;
    logic                 fifo_wr;
    logic                 fifo_rd;
    logic                 fifo_nempty;

    // Credit check: a read may only be issued if the FIFO has room for it
    // after every read already in flight has landed.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < pRLAT; i++) begin
            inflight = inflight + (pFIFO_W + 2)'(pipe_val[i]);
        end
        occupancy   = (pFIFO_W + 2)'(fifo_cnt) + inflight;
        issue       = (state == READ) && (occupancy < cDEPTH_V);
        issue_sop   = (addr == '0);
        issue_eop   = (addr == len);
        val_next    = pRLAT'({pipe_val, issue});
        sop_next    = pRLAT'({pipe_sop, issue & issue_sop});
        eop_next    = pRLAT'({pipe_eop, issue & issue_eop});
        pipe_drains = (val_next == '0);
        fifo_nempty = (fifo_cnt != '0);
        fifo_wr     = pipe_val[pRLAT-1];
        fifo_rd     = fifo_nempty && ordy;
    end

    // Block sequencing: latch length/tag, walk addresses, release the bank
    // once the pipe is empty, then wait one cycle for the buffer to update.
    always_ff @(posedge iclk) begin
        if (ireset) begin
            state  <= IDLE;
            addr   <= '0;
            len    <= '0;
            tag    <= '0;
            rempty <= 1'b0;
        end else if (iclkena) begin
            rempty <= 1'b0;
            case (state)
                IDLE: begin
                    if (!ibuf_empty) begin
                        len   <= ilen_m1;
                        tag   <= ibuf_rtag;
                        addr  <= '0;
                        state <= READ;
                    end
                end
                READ: begin
                    if (issue) begin
                        if (addr == len) begin
                            state <= DRAIN;
                        end else begin
                            addr <= addr + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (pipe_drains) begin
                        rempty <= 1'b1;
                        state  <= GAP;
                    end
                end
                GAP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Read-latency pipe: tracks issued reads and their sop/eop flags until
    // the matching RAM data shows up.
    always_ff @(posedge iclk) begin
        if (ireset) begin
            pipe_val <= '0;
            pipe_sop <= '0;
            pipe_eop <= '0;
        end else if (iclkena) begin
            pipe_val <= val_next;
            pipe_sop <= sop_next;
            pipe_eop <= eop_next;
        end
    end

    // Skid FIFO pointers and fill count; simultaneous write and read allowed.
    always_ff @(posedge iclk) begin
        if (ireset) begin
            wptr     <= '0;
            rptr     <= '0;
            fifo_cnt <= '0;
        end else if (iclkena) begin
            if (fifo_wr) begin
                wptr <= wptr + 1'b1;
            end
            if (fifo_rd) begin
                rptr <= rptr + 1'b1;
            end
            case ({fifo_wr, fifo_rd})
                2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    // FIFO storage: each entry carries its own tag so blocks never mix.
    always_ff @(posedge iclk) begin
        if (iclkena && fifo_wr) begin
            mem_dat[wptr] <= ibuf_rdata;
            mem_tag[wptr] <= tag;
            mem_sop[wptr] <= pipe_sop[pRLAT-1];
            mem_eop[wptr] <= pipe_eop[pRLAT-1];
        end
    end

    assign obuf_raddr  = addr;
    assign obuf_rempty = rempty;
    assign obusy       = (state != IDLE);
    assign oval        = fifo_nempty;
    assign odat        = fifo_nempty ? mem_dat[rptr] : '0;
    assign otag        = fifo_nempty ? mem_tag[rptr] : '0;
    assign osop        = fifo_nempty ? mem_sop[rptr] : 1'b0;
    assign oeop        = fifo_nempty ? mem_eop[rptr] : 1'b0;

endmodule

// File: tb/tb_rsc_dec_output_reader.sv
// Bench for rsc_dec_output_reader: models the output buffer (banks, tags,
// registered read) and checks the packet stream against a word scoreboard.
module tb_rsc_dec_output_reader;

    localparam int ADDR_W = 8;
    localparam int RDAT_W = 2;
    localparam int TAG_W  = 8;
    localparam int RLAT   = 1;
    localparam int FIFO_W = 2;
    localparam int NB     = 16;

    typedef struct packed {
        logic [RDAT_W-1:0] dat;
        logic              sop;
        logic              eop;
        logic [TAG_W-1:0]  tag;
    } word_t;

    logic              iclk;
    logic              ireset;
    logic              iclkena;
    logic [ADDR_W-1:0] ilen_m1;
    logic              ibuf_empty;
    logic [RDAT_W-1:0] ibuf_rdata;
    logic [TAG_W-1:0]  ibuf_rtag;
    logic [ADDR_W-1:0] obuf_raddr;
    logic              obuf_rempty;
    logic              oval;
    logic              osop;
    logic              oeop;
    logic [RDAT_W-1:0] odat;
    logic [TAG_W-1:0]  otag;
    logic              ordy;
    logic              obusy;

    logic [RDAT_W-1:0] bank_data [NB][2**ADDR_W];
    logic [TAG_W-1:0]  bank_tag  [NB];
    logic [ADDR_W-1:0] bank_len  [NB];
    logic [RDAT_W-1:0] rd_pipe   [RLAT];
    int                nbanks;
    int                head;

    word_t             exp_q [$];
    int                xfer_log [$];
    int                cyc;
    int                rel_count;
    int                rel_cyc;
    int                tests;
    int                fails;

    rsc_dec_output_reader #(
        .pADDR_W (ADDR_W),
        .pRDAT_W (RDAT_W),
        .pTAG_W  (TAG_W),
        .pRLAT   (RLAT),
        .pFIFO_W (FIFO_W)
    ) dut (
        .iclk        (iclk),
        .ireset      (ireset),
        .iclkena     (iclkena),
        .ilen_m1     (ilen_m1),
        .ibuf_empty  (ibuf_empty),
        .ibuf_rdata  (ibuf_rdata),
        .ibuf_rtag   (ibuf_rtag),
        .obuf_raddr  (obuf_raddr),
        .obuf_rempty (obuf_rempty),
        .oval        (oval),
        .osop        (osop),
        .oeop        (oeop),
        .odat        (odat),
        .otag        (otag),
        .ordy        (ordy),
        .obusy       (obusy)
    );

    // Free-running clock, period 10.
    initial begin
        iclk = 1'b0;
        forever #5 iclk = ~iclk;
    end

    // Global time limit so the run always ends.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic check_value(input string name, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("[TB] FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    task automatic update_buf_ports();
        ibuf_empty = (head >= nbanks);
        ibuf_rtag  = (head < nbanks) ? bank_tag[head] : '0;
        ilen_m1    = (head < nbanks) ? bank_len[head] : '0;
    endtask

    task automatic push_bank_words(input int b);
        word_t w;
        for (int i = 0; i <= int'(bank_len[b]); i++) begin
            w.dat = bank_data[b][i];
            w.sop = (i == 0);
            w.eop = (i == int'(bank_len[b]));
            w.tag = bank_tag[b];
            exp_q.push_back(w);
        end
    endtask

    task automatic add_bank(input logic [TAG_W-1:0] t, input logic [ADDR_W-1:0] len);
        bank_tag[nbanks] = t;
        bank_len[nbanks] = len;
        for (int i = 0; i < 2**ADDR_W; i++) begin
            bank_data[nbanks][i] = RDAT_W'($urandom);
        end
        push_bank_words(nbanks);
        nbanks++;
        update_buf_ports();
    endtask

    task automatic checkOutput();
        word_t e;
        if (oval === 1'b1 && ordy && iclkena && !ireset) begin
            xfer_log.push_back(cyc);
            check_value("word_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check_value("word", 64'({odat, osop, oeop, otag}), 64'(e));
            end
        end
        if (obuf_rempty === 1'b1 && iclkena && !ireset) begin
            rel_count++;
            rel_cyc = cyc;
        end
    endtask

    task automatic applyStimulus(input logic rdy_v, input logic ena_v);
        logic [ADDR_W-1:0] a_s;
        logic              rel_s;
        ordy    = rdy_v;
        iclkena = ena_v;
        #1;
        checkOutput();
        a_s   = obuf_raddr;
        rel_s = (obuf_rempty === 1'b1) && ena_v && !ireset;
        @(posedge iclk);
        #1;
        cyc++;
        if (ena_v) begin
            for (int i = RLAT - 1; i > 0; i--) begin
                rd_pipe[i] = rd_pipe[i-1];
            end
            rd_pipe[0] = (head < nbanks) ? bank_data[head][a_s] : '0;
            ibuf_rdata = rd_pipe[RLAT-1];
        end
        if (rel_s) begin
            head++;
        end
        update_buf_ports();
        @(negedge iclk);
    endtask

    // mode 0: ordy=1, mode 1: toggle, mode 2: random
    task automatic run_drain(input int mode, input bit ena_rand, input int max_cyc);
        int  n;
        logic r;
        logic en;
        n = 0;
        while (!(exp_q.size() == 0 && head == nbanks && obusy === 1'b0 && oval === 1'b0) && n < max_cyc) begin
            r  = (mode == 0) ? 1'b1 : (mode == 1) ? n[0] : ($urandom_range(0, 3) != 0);
            en = ena_rand ? ($urandom_range(0, 4) != 0) : 1'b1;
            applyStimulus(r, en);
            n++;
        end
        check_value("drain_in_time", 64'(n < max_cyc), 64'd1);
    endtask

    task automatic check_all_zero(input string name);
        check_value({name, "_oval"},   64'(oval),        64'd0);
        check_value({name, "_osop"},   64'(osop),        64'd0);
        check_value({name, "_oeop"},   64'(oeop),        64'd0);
        check_value({name, "_odat"},   64'(odat),        64'd0);
        check_value({name, "_otag"},   64'(otag),        64'd0);
        check_value({name, "_raddr"},  64'(obuf_raddr),  64'd0);
        check_value({name, "_rempty"}, 64'(obuf_rempty), 64'd0);
        check_value({name, "_obusy"},  64'(obusy),       64'd0);
    endtask

    function automatic bit consecutive(input int from, input int to);
        bit ok;
        ok = 1'b1;
        for (int i = from + 1; i <= to; i++) begin
            if (xfer_log[i] - xfer_log[i-1] != 1) ok = 1'b0;
        end
        return ok;
    endfunction

    initial begin
        int rel0;
        int n;
        logic [ADDR_W-1:0] raddr_s;
        tests = 0; fails = 0; cyc = 0; rel_count = 0; rel_cyc = -1;
        nbanks = 0; head = 0;
        ireset = 1'b1; iclkena = 1'b0; ordy = 1'b0; ibuf_rdata = '0;
        for (int i = 0; i < RLAT; i++) rd_pipe[i] = '0;
        update_buf_ports();
        @(negedge iclk);

        // Reset taken even with the clock enable low.
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0);
        check_all_zero("reset");
        ireset = 1'b0;
        applyStimulus(1'b1, 1'b1);

        // 8-word block, tag A5, ordy held high.
        rel0 = rel_count; xfer_log.delete();
        add_bank(8'hA5, 8'd7);
        run_drain(0, 1'b0, 200);
        check_value("blkA_words", 64'(xfer_log.size()), 64'd8);
        if (xfer_log.size() == 8) begin
            check_value("blkA_consecutive", 64'(consecutive(0, 7)), 64'd1);
            check_value("blkA_rempty_cycle", 64'(rel_cyc), 64'(xfer_log[7]));
        end
        check_value("blkA_releases", 64'(rel_count - rel0), 64'd1);

        // Single-word block.
        rel0 = rel_count; xfer_log.delete();
        add_bank(8'h42, 8'd0);
        run_drain(0, 1'b0, 100);
        check_value("len0_words", 64'(xfer_log.size()), 64'd1);
        check_value("len0_releases", 64'(rel_count - rel0), 64'd1);
        applyStimulus(1'b1, 1'b1);
        check_value("len0_idle", 64'(obusy), 64'd0);

        // ordy toggling with a long stall in the middle.
        rel0 = rel_count;
        add_bank(8'h77, 8'd31);
        for (int i = 0; i < 10; i++) applyStimulus(logic'(i % 2 == 0), 1'b1);
        raddr_s = '0;
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b0, 1'b1);
            if (i == 9) raddr_s = obuf_raddr;
        end
        check_value("stall_raddr_frozen", 64'(obuf_raddr), 64'(raddr_s));
        check_value("stall_oval_held", 64'(oval), 64'd1);
        run_drain(1, 1'b0, 400);
        check_value("toggle_releases", 64'(rel_count - rel0), 64'd1);

        // Two banks back to back, ibuf_empty never rises between them.
        rel0 = rel_count; xfer_log.delete();
        add_bank(8'h11, 8'd5);
        add_bank(8'h22, 8'd6);
        run_drain(0, 1'b0, 300);
        check_value("b2b_words", 64'(xfer_log.size()), 64'd13);
        if (xfer_log.size() == 13) begin
            check_value("b2b_blk1_consecutive", 64'(consecutive(0, 5)), 64'd1);
            check_value("b2b_blk2_consecutive", 64'(consecutive(6, 12)), 64'd1);
            check_value("b2b_gap", 64'(xfer_log[6] - xfer_log[5]), 64'(RLAT + 3));
        end
        check_value("b2b_releases", 64'(rel_count - rel0), 64'd2);

        // Reset in the middle of a block at address 3.
        rel0 = rel_count;
        add_bank(8'h5C, 8'd15);
        n = 0;
        while (obuf_raddr !== 8'd3 && n < 30) begin
            applyStimulus(1'b0, 1'b1);
            n++;
        end
        check_value("midreset_addr3_reached", 64'(obuf_raddr), 64'd3);
        ireset = 1'b1;
        applyStimulus(1'b0, 1'b1);
        ireset = 1'b0;
        check_all_zero("midreset");
        check_value("midreset_no_release", 64'(rel_count - rel0), 64'd0);
        exp_q.delete();
        for (int b = head; b < nbanks; b++) push_bank_words(b);
        run_drain(0, 1'b0, 200);
        check_value("midreset_reread_release", 64'(rel_count - rel0), 64'd1);

        // Clock enable low during READ and during the release pulse.
        rel0 = rel_count;
        add_bank(8'h3C, 8'd12);
        repeat (3) applyStimulus(1'b1, 1'b1);
        repeat (5) applyStimulus(1'b1, 1'b0);
        n = 0;
        while (obuf_rempty !== 1'b1 && n < 100) begin
            applyStimulus(1'b1, 1'b1);
            n++;
        end
        check_value("ena_rempty_seen", 64'(obuf_rempty), 64'd1);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 1'b0);
            check_value("ena_rempty_stretch", 64'(obuf_rempty), 64'd1);
        end
        run_drain(0, 1'b0, 200);
        check_value("ena_release_once", 64'(rel_count - rel0), 64'd1);

        // Random lengths, random ordy and random clock enable.
        rel0 = rel_count;
        for (int b = 0; b < 4; b++) begin
            add_bank(TAG_W'($urandom), ADDR_W'($urandom_range(0, 20)));
        end
        run_drain(2, 1'b1, 3000);
        check_value("random_releases", 64'(rel_count - rel0), 64'd4);

        check_value("total_releases", 64'(rel_count), 64'(nbanks));
        check_value("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
